dp_fifo16: RTL and testbench
============================

// Module: dp_fifo16
// PURPOSE
//  Receiving end of the 16-bit VU datapath buffer chain: a small elastic
//  queue that accepts buffered lane data and holds it until the downstream
//  datapath stage is ready. Valid/ready on both sides.
//  Decouples producer and consumer timing on one vector lane.
//  One instance per lane; sits between the lane buffer and the lane consumer.
// PARAMETERS
//  WIDTH   16  data width in bits; fixed at DP_LANE_W for VU lanes
//  DEPTH   4   number of entries; power of 2, range 2..16
//  AW      2   log2(DEPTH); derived, never overridden
// PORTS
//  clk        in   1       clock; all state updates on the rising edge
//  reset      in   1       asynchronous, active-high
//  in_valid   in   1       producer has data on in_data
//  in_ready   out  1       queue accepts data this cycle
//  in_data    in   WIDTH   write data
//  out_valid  out  1       out_data holds the oldest entry
//  out_ready  in   1       consumer takes out_data this cycle
//  out_data   out  WIDTH   head-of-queue data
//  count      out  AW+1    occupancy, 0..DEPTH
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0,
//    out_valid=0, in_ready=1. Storage contents are not reset.
//    out_data is don't-care while out_valid=0.
//  - While reset is asserted, in_valid and out_ready are ignored.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). This is a combinational decode of
//    registered count, with no path from out_ready. A full queue does not
//    accept a push in the same cycle as a pop.
//  - out_valid = (count != 0). out_data = mem[rd_ptr], driven from
//    registers with no input-to-output bypass.
//  - Latency: a word pushed into an empty queue at edge N appears with
//    out_valid=1 after edge N; minimum 1 cycle.
//  - count update per edge:
//      push & !pop -> +1
//      pop & !push -> -1
//      both or neither -> unchanged
//  - Simultaneous push and pop, 0<count<DEPTH: both pointers advance;
//    count holds; order is preserved.
//  - Empty: pop is impossible because out_valid=0. out_ready is ignored.
//  - Full: push is impossible because in_ready=0. in_valid is ignored and
//    data is held by the producer.
//  - Pointers are AW bits wide and wrap DEPTH-1 -> 0 naturally.
//  - Ordering: strict FIFO. No data is dropped or duplicated.
//  - Reset mid-operation: all queued data is discarded; state returns to
//    empty immediately, without waiting for a clock edge.
//  - Assertions (sim only):
//      count <= DEPTH
//      no push when full
//      no pop when empty
// STRUCTURE
//  - Shared package dp_pkg: DP_LANE_W=16 and a clog2 helper function.
//  - Sub-module dp_fifo16_mem: DEPTH x WIDTH register array, with one write
//    port (we, waddr, wdata) and one asynchronous read port (raddr, rdata).
//  - Pointers, count and flag logic live in dp_fifo16.
// TESTING
//  1. Reset, then idle with in_valid=0 -> count=0, out_valid=0,
//     in_ready=1 for 10 cycles.
//  2. Push 0x1234 with out_ready=0 -> next cycle out_valid=1,
//     out_data=0x1234, count=1.
//  3. Push 0xA000..0xA003 with out_ready=0 -> count=4, in_ready=0;
//     a fifth push of 0xBEEF is held. Then drain with out_ready=1:
//     outputs A000, A001, A002, A003 in order.
//  4. At count=2, hold push and pop together for 20 cycles
//     (data 0..19) -> count stays 2; outputs in order 0..19 after the two
//     preloaded words; pointers wrap correctly.
//  5. Full queue with in_valid=1 and out_ready=1 in the same cycle ->
//     pop occurs, push is refused (count=3); the push lands next cycle
//     (count=4).
//  6. Assert reset asynchronously between edges with count=3 -> count=0,
//     out_valid=0, in_ready=1 immediately. After release, first push
//     0x5A5A is output first.

Source files
------------

// File: rtl/dp_pkg.sv
// dp_pkg: shared datapath constants and helpers for the VU lane blocks
package dp_pkg;
  localparam int DP_LANE_W = 16;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r = r + 1;
    return r;
  endfunction
endpackage

// File: rtl/dp_fifo16_if.sv
// dp_fifo16_if: valid/ready bundle for one lane queue
// master: producer/consumer side (drives in_valid, in_data, out_ready)
// slave:  queue side (drives in_ready, out_valid, out_data, count)
interface dp_fifo16_if import dp_pkg::*; #(
  parameter int WIDTH = DP_LANE_W,
  parameter int DEPTH = 4
);
  localparam int AW = clog2(DEPTH);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW:0]      count;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, count);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, count);
endinterface

// File: rtl/dp_fifo16_mem.sv
// dp_fifo16_mem: DEPTH x WIDTH register array, one write port, one async read port
// Ports: clk, we/waddr/wdata (write on rising edge), raddr/rdata (combinational read)
module dp_fifo16_mem import dp_pkg::*; #(
  parameter int WIDTH = DP_LANE_W,
  parameter int DEPTH = 4,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end
  // Storage is intentionally not reset; out_data is don't-care while empty.
  always_ff @(posedge clk) mem_q <= mem_d;
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/dp_fifo16.sv
// dp_fifo16: elastic valid/ready lane queue between the lane buffer and the lane consumer
// Ports: clk, reset (async assert, active-high), bus (slave side of dp_fifo16_if:
//   in_valid/in_ready/in_data producer side, out_valid/out_ready/out_data consumer side, count)
module dp_fifo16 import dp_pkg::*; #(
  parameter int WIDTH = DP_LANE_W,
  parameter int DEPTH = 4
) (
  input logic        clk,
  input logic        reset,
  dp_fifo16_if.slave bus
);
  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;
  // Flags decode registered count only, so out_ready never reaches in_ready.
  assign bus.in_ready  = count_q != FULL;
  assign bus.out_valid = count_q != '0;
  assign bus.count     = count_q;
  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  dp_fifo16_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.in_data),
    .raddr (rd_ptr_q),
    .rdata (bus.out_data)
  );
  a_count_range: assert property (@(posedge clk) disable iff (reset) count_q <= FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && count_q == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(pop && count_q == '0));
endmodule

// File: tb/tb_dp_fifo16.sv
// tb_dp_fifo16: directed bench for dp_fifo16 with a queue reference model
module tb_dp_fifo16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  logic [15:0] mq [$];
  logic [15:0] got [$];
  dp_fifo16_if bus ();
  dp_fifo16 dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_got(input string n, input logic [15:0] exp [$]);
    chk({n, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(n, got[i], exp[i]);
    got.delete();
  endtask
  // Reference model: plain queue of at most 4 words, cleared by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) mq.delete();
    else begin
      bit pu, po;
      pu = bus.in_valid && mq.size() < 4;
      po = bus.out_ready && mq.size() > 0;
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(bus.in_data);
    end
  end
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("count", 32'(bus.count), mq.size());
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != 4));
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("out_data", 32'(bus.out_data), 32'(mq[0]));
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    end
  end
  initial begin
    logic [15:0] e [$];
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    #2 reset = 1'b0;
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk_en = 1'b1;
    repeat (10) step();
    chk("idle_count", 32'(bus.count), 0);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h1234;
    step();
    bus.in_valid = 1'b0;
    chk("t2_out_valid", 32'(bus.out_valid), 1);
    chk("t2_out_data", 32'(bus.out_data), 32'h1234);
    chk("t2_count", 32'(bus.count), 1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'hA000 + 16'(i);
      step();
    end
    chk("t3_count_full", 32'(bus.count), 4);
    chk("t3_in_ready", 32'(bus.in_ready), 0);
    bus.in_data = 16'hBEEF;
    step();
    step();
    chk("t3_held_count", 32'(bus.count), 4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    bus.out_ready = 1'b0;
    chk("t3_empty", 32'(bus.count), 0);
    e = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    chk_got("t3_order", e);
    bus.in_valid = 1'b1;
    bus.in_data = 16'h00AA;
    step();
    bus.in_data = 16'h00BB;
    step();
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 16'(i);
      bus.out_ready = 1'b1;
      step();
      chk("t4_count", 32'(bus.count), 2);
    end
    bus.in_valid = 1'b0;
    repeat (2) step();
    bus.out_ready = 1'b0;
    e = '{16'h00AA, 16'h00BB};
    for (int i = 0; i < 20; i++) e.push_back(16'(i));
    chk_got("t4_order", e);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h00C0 + 16'(i);
      step();
    end
    bus.in_data = 16'h00C4;
    bus.out_ready = 1'b1;
    step();
    chk("t5_pop_only", 32'(bus.count), 3);
    bus.out_ready = 1'b0;
    step();
    chk("t5_push_lands", 32'(bus.count), 4);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) step();
    bus.out_ready = 1'b0;
    e = '{16'h00C0, 16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
    chk_got("t5_order", e);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 16'h00D0 + 16'(i);
      step();
    end
    bus.in_valid = 1'b0;
    chk("t6_pre_count", 32'(bus.count), 3);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_count", 32'(bus.count), 0);
    chk("t6_async_out_valid", 32'(bus.out_valid), 0);
    chk("t6_async_in_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data = 16'hFFFF;
    bus.out_ready = 1'b1;
    step();
    chk("t6_ignored_count", 32'(bus.count), 0);
    #2 reset = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = 16'h5A5A;
    step();
    bus.in_data = 16'h0001;
    step();
    bus.in_valid = 1'b0;
    chk("t6_first_out", 32'(bus.out_data), 32'h5A5A);
    chk("t6_count", 32'(bus.count), 2);
    got.delete();
    bus.out_ready = 1'b1;
    repeat (2) step();
    bus.out_ready = 1'b0;
    e = '{16'h5A5A, 16'h0001};
    chk_got("t6_order", e);
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
